// File: rtl/msp_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// msp_tx_arbiter_if
//   Bundles the requester-side and msp_tx-side signals of msp_tx_arbiter.
//
//   Requester side : req_cmd, req_len, req_payload, req_valid -> arbiter
//                    req_ready <- arbiter (one-cycle accept pulse)
//   msp_tx side    : out_cmd, out_len, out_payload, out_valid <- arbiter
//                    out_ready, tx_busy -> arbiter
//   Status         : grant_id, len_err <- arbiter
//   Optional       : grant_cnt, len_err_cnt exist only when
//                    MSP_TX_ARB_STATS_EN is defined.
//
//   modport slave  : the arbiter itself.
//   modport master : the environment (requesters plus msp_tx).
// ---------------------------------------------------------------------------
interface msp_tx_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_PAYLOAD = 16
);
  logic [NUM_REQ*8-1:0]             req_cmd;
  logic [NUM_REQ*8-1:0]             req_len;
  logic [NUM_REQ*MAX_PAYLOAD*8-1:0] req_payload;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [7:0]                       out_cmd;
  logic [7:0]                       out_len;
  logic [MAX_PAYLOAD*8-1:0]         out_payload;
  logic                             out_valid;
  logic                             out_ready;
  logic                             tx_busy;
  logic [2:0]                       grant_id;
  logic                             len_err;
`ifdef MSP_TX_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]            grant_cnt;
  logic [7:0]                       len_err_cnt;
`endif

  modport slave (
    input  req_cmd, req_len, req_payload, req_valid, out_ready, tx_busy,
    output req_ready, out_cmd, out_len, out_payload, out_valid, grant_id, len_err
`ifdef MSP_TX_ARB_STATS_EN
    , output grant_cnt, len_err_cnt
`endif
  );

  modport master (
    output req_cmd, req_len, req_payload, req_valid, out_ready, tx_busy,
    input  req_ready, out_cmd, out_len, out_payload, out_valid, grant_id, len_err
`ifdef MSP_TX_ARB_STATS_EN
    , input grant_cnt, len_err_cnt
`endif
  );
endinterface

// File: rtl/msp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// msp_tx_arbiter
//   Shares one msp_tx transmitter between NUM_REQ response sources.
//   A round-robin pick latches one requester's cmd/len/payload, offers it
//   to msp_tx over valid/ready, then waits for msp_tx to go idle before the
//   next grant, so only one frame is ever in flight.
//
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     bus    : msp_tx_arbiter_if.slave (requester inputs, req_ready pulses,
//              out_* towards msp_tx, out_ready/tx_busy from msp_tx,
//              grant_id, len_err)
//
//   Optional feature: define MSP_TX_ARB_STATS_EN to add saturating
//   per-requester grant counters (grant_cnt) and a clamp counter
//   (len_err_cnt).
// ---------------------------------------------------------------------------
module msp_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_PAYLOAD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  msp_tx_arbiter_if.slave bus
);
  localparam int         PW      = MAX_PAYLOAD * 8;
  localparam logic [7:0] LEN_MAX = 8'(MAX_PAYLOAD);
  localparam logic [2:0] PTR_RST = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_rr_ptr;
  logic [2:0]         r_grant_id;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [7:0]         r_out_cmd;
  logic [7:0]         r_out_len;
  logic [PW-1:0]      r_out_payload;
  logic               r_out_valid;
  logic               r_len_err;

  logic               w_any;
  logic [2:0]         w_sel;
  logic [7:0]         w_cmd;
  logic [7:0]         w_len;
  logic [PW-1:0]      w_payload;
  logic               w_clamp;
  logic               w_grant;

  // Round-robin pick: scan downwards so the last hit is the nearest set
  // bit after r_rr_ptr (distance 1 wins, distance NUM_REQ = r_rr_ptr itself).
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_sel = 3'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Select the chosen requester's fields.
  always_comb begin
    w_cmd     = '0;
    w_len     = '0;
    w_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == 3'(i)) begin
        w_cmd     = bus.req_cmd[i*8 +: 8];
        w_len     = bus.req_len[i*8 +: 8];
        w_payload = bus.req_payload[i*PW +: PW];
      end
    end
  end

  assign w_clamp = (w_len > LEN_MAX);
  assign w_grant = (r_state == S_IDLE) && !bus.tx_busy && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= PTR_RST;
      r_grant_id    <= '0;
      r_req_ready   <= '0;
      r_out_cmd     <= '0;
      r_out_len     <= '0;
      r_out_payload <= '0;
      r_out_valid   <= 1'b0;
      r_len_err     <= 1'b0;
    end else begin
      // Accept and clamp indications are single-cycle pulses.
      r_req_ready <= '0;
      r_len_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_out_cmd     <= w_cmd;
            r_out_len     <= w_clamp ? LEN_MAX : w_len;
            r_out_payload <= w_payload;
            r_len_err     <= w_clamp;
            r_out_valid   <= 1'b1;
            r_grant_id    <= w_sel;
            r_rr_ptr      <= w_sel;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (w_sel == 3'(i)) r_req_ready[i] <= 1'b1;
            end
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // msp_tx raises busy the cycle after the handshake, so the first
          // idle sample here means the frame has really left.
          if (!bus.tx_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.out_cmd     = r_out_cmd;
  assign bus.out_len     = r_out_len;
  assign bus.out_payload = r_out_payload;
  assign bus.out_valid   = r_out_valid;
  assign bus.grant_id    = r_grant_id;
  assign bus.len_err     = r_len_err;

`ifdef MSP_TX_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] r_grant_cnt;
  logic [7:0]            r_len_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt   <= '0;
      r_len_err_cnt <= '0;
    end else if (w_grant) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_sel == 3'(i) && r_grant_cnt[i*16 +: 16] != 16'hFFFF)
          r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (w_clamp && r_len_err_cnt != 8'hFF)
        r_len_err_cnt <= r_len_err_cnt + 8'd1;
    end
  end

  assign bus.grant_cnt   = r_grant_cnt;
  assign bus.len_err_cnt = r_len_err_cnt;
`endif
endmodule

// File: tb/tb_msp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_msp_tx_arbiter
//   Self-checking bench for msp_tx_arbiter with NUM_REQ=3, MAX_PAYLOAD=16.
//   A small msp_tx model raises tx_busy for busy_len cycles after each
//   handshake. Directed scenarios are followed by a randomized run checked
//   against a round-robin reference built from the arbitration rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msp_tx_arbiter;
  localparam int NR = 3;
  localparam int MP = 16;
  localparam int PW = MP * 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   busy_len = 1;
  int   busy_cnt = 0;
  logic tx_hs;

  msp_tx_arbiter_if #(.NUM_REQ(NR), .MAX_PAYLOAD(MP)) bus ();

  msp_tx_arbiter #(.NUM_REQ(NR), .MAX_PAYLOAD(MP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // msp_tx model: busy from the cycle after a handshake for busy_len cycles.
  always @(posedge clk) begin
    tx_hs = bus.out_valid && bus.out_ready;
    #1;
    if (!rst_n)          busy_cnt = 0;
    else if (tx_hs)      busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    bus.tx_busy = (busy_cnt > 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [7:0] cmd, input logic [7:0] len,
                         input logic [PW-1:0] pl);
    bus.req_cmd[i*8 +: 8]       = cmd;
    bus.req_len[i*8 +: 8]       = len;
    bus.req_payload[i*PW +: PW] = pl;
    bus.req_valid[i]            = 1'b1;
  endtask

  function automatic logic [PW-1:0] rand_pl();
    logic [PW-1:0] p;
    for (int w = 0; w < PW/32; w++) p[w*32 +: 32] = $urandom();
    return p;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < NR; i++) if (v[i]) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  // Reference rule: first pending requester after the last grant, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] p, input int last);
    for (int d = 1; d <= NR; d++) if (p[(last + d) % NR]) return (last + d) % NR;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    busy_len      = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    checks++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready: got %b want 000", bus.req_ready);
    checks++; if (bus.out_cmd !== 8'h00 || bus.out_len !== 8'h00) $display("FAIL reset_cmd_len: got %h/%h want 00/00", bus.out_cmd, bus.out_len);
    checks++; if (bus.out_payload !== '0) $display("FAIL reset_payload: got %h want 0", bus.out_payload);
    checks++; if (bus.len_err !== 1'b0 || bus.grant_id !== 3'd0) $display("FAIL reset_status: got len_err=%b grant_id=%0d want 0/0", bus.len_err, bus.grant_id);
    if (checks == 5 && errors == 0) begin end
    errors += (bus.out_valid !== 1'b0) + (bus.req_ready !== '0) + (bus.out_cmd !== 8'h00 || bus.out_len !== 8'h00)
            + (bus.out_payload !== '0) + (bus.len_err !== 1'b0 || bus.grant_id !== 3'd0);
    $display("reset: outputs idle after reset release");
  endtask

  task automatic test_single();
    logic [PW-1:0] pl;
    do_reset();
    pl = '0;
    pl[23:0] = 24'h030201;
    set_req(0, 8'h65, 8'd3, pl);
    tick();
    checks++; if (bus.req_ready !== 3'b001 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_grant: got ready=%b valid=%b want 001/1", bus.req_ready, bus.out_valid); end
    checks++; if (bus.out_cmd !== 8'h65 || bus.out_len !== 8'd3) begin errors++; $display("FAIL single_cmd_len: got %h/%0d want 65/3", bus.out_cmd, bus.out_len); end
    checks++; if (bus.out_payload !== pl || bus.grant_id !== 3'd0) begin errors++; $display("FAIL single_payload_id: got %h id=%0d want %h id=0", bus.out_payload, bus.grant_id, pl); end
    bus.req_valid[0] = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 3'b000) begin errors++; $display("FAIL single_handshake: got valid=%b ready=%b want 0/000", bus.out_valid, bus.req_ready); end
    $display("single: cmd=%h len=%0d granted to %0d", bus.out_cmd, bus.out_len, bus.grant_id);
  endtask

  task automatic test_contention();
    int   order[$];
    int   g;
    logic busy_prev;
    logic saw_busy;
    do_reset();
    busy_len = 20;
    set_req(0, 8'h11, 8'd2, rand_pl());
    set_req(1, 8'h22, 8'd4, rand_pl());
    saw_busy = 1'b0;
    for (int t = 0; t < 200 && order.size() < 2; t++) begin
      busy_prev = bus.tx_busy;
      tick();
      if (bus.req_ready != '0) begin
        g = oh_idx(bus.req_ready);
        $display("contention: grant to %0d at cycle %0d", g, t);
        if (order.size() == 1) begin
          checks++;
          if (!saw_busy || busy_prev) begin errors++; $display("FAIL contention_wait_busy: got saw_busy=%b busy_prev=%b want 1/0", saw_busy, busy_prev); end
        end
        order.push_back(g);
        if (g >= 0) bus.req_valid[g] = 1'b0;
      end
      if (bus.tx_busy) saw_busy = 1'b1;
    end
    checks++;
    if (order.size() != 2) begin
      errors++; $display("FAIL contention_timeout: got %0d grants want 2", order.size());
    end else begin
      checks++; if (order[0] != 0 || order[1] != 1) begin errors++; $display("FAIL contention_order: got %0d,%0d want 0,1", order[0], order[1]); end
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int exp_id;
    logic [NR-1:0] exp_rdy;
    do_reset();
    busy_len = 3;
    for (int i = 0; i < NR; i++) set_req(i, 8'(8'h30 + i), 8'(i + 1), rand_pl());
    for (int t = 0; t < 400 && n < 6; t++) begin
      tick();
      if (bus.req_ready != '0) begin
        exp_id = n % NR;
        exp_rdy = '0;
        exp_rdy[exp_id] = 1'b1;
        $display("round_robin: grant %0d to %0d", n, bus.grant_id);
        checks++;
        if (bus.grant_id !== 3'(exp_id) || bus.req_ready !== exp_rdy) begin
          errors++; $display("FAIL rr_grant%0d: got id=%0d ready=%b want id=%0d ready=%b", n, bus.grant_id, bus.req_ready, exp_id, exp_rdy);
        end
        n++;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL rr_timeout: got %0d grants want 6", n); end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] pl;
    do_reset();
    bus.out_ready = 1'b0;
    pl = rand_pl();
    set_req(1, 8'hA5, 8'd5, pl);
    tick();
    checks++; if (bus.req_ready !== 3'b010 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_grant: got ready=%b valid=%b want 010/1", bus.req_ready, bus.out_valid); end
    bus.req_valid[1] = 1'b0;
    set_req(0, 8'h5A, 8'd1, rand_pl());
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.req_ready !== '0 || bus.out_cmd !== 8'hA5 ||
          bus.out_len !== 8'd5 || bus.out_payload !== pl) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b cmd=%h len=%0d want 1/000/a5/5", t, bus.out_valid, bus.req_ready, bus.out_cmd, bus.out_len);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== '0) begin errors++; $display("FAIL bp_handshake: got valid=%b ready=%b want 0/000", bus.out_valid, bus.req_ready); end
    $display("backpressure: frame from 1 held 10 cycles then accepted");
    bus.req_valid = '0;
  endtask

  task automatic test_clamp();
    logic [PW-1:0] pl;
    int pulses = 0;
    do_reset();
    pl = rand_pl();
    set_req(2, 8'h6C, 8'd20, pl);
    tick();
    checks++; if (bus.req_ready !== 3'b100 || bus.out_len !== 8'd16 || bus.len_err !== 1'b1) begin errors++; $display("FAIL clamp_len: got ready=%b len=%0d len_err=%b want 100/16/1", bus.req_ready, bus.out_len, bus.len_err); end
    checks++; if (bus.out_payload !== pl || bus.out_cmd !== 8'h6C) begin errors++; $display("FAIL clamp_data: got cmd=%h payload=%h want 6c/%h", bus.out_cmd, bus.out_payload, pl); end
    bus.req_valid[2] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.len_err) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clamp_single_pulse: got %0d extra pulses want 0", pulses); end
`ifdef MSP_TX_ARB_STATS_EN
    checks++; if (bus.len_err_cnt !== 8'd1) begin errors++; $display("FAIL clamp_len_err_cnt: got %0d want 1", bus.len_err_cnt); end
    checks++; if (bus.grant_cnt[2*16 +: 16] !== 16'd1) begin errors++; $display("FAIL clamp_grant_cnt2: got %0d want 1", bus.grant_cnt[2*16 +: 16]); end
`endif
    $display("clamp: len 20 forwarded as %0d", bus.out_len);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    set_req(0, 8'h77, 8'd2, rand_pl());
    tick();
    checks++; if (bus.req_ready !== 3'b001 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got ready=%b valid=%b want 001/1", bus.req_ready, bus.out_valid); end
    bus.req_valid[0] = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== '0) begin errors++; $display("FAIL rstmid_async: got valid=%b ready=%b want 0/000", bus.out_valid, bus.req_ready); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    set_req(0, 8'h01, 8'd1, rand_pl());
    set_req(1, 8'h02, 8'd1, rand_pl());
    tick();
    checks++; if (bus.req_ready !== 3'b001 || bus.grant_id !== 3'd0) begin errors++; $display("FAIL rstmid_first_grant: got ready=%b id=%0d want 001/0", bus.req_ready, bus.grant_id); end
    $display("reset_mid: first grant after reset to %0d", bus.grant_id);
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    logic [7:0]    m_cmd [NR];
    logic [7:0]    m_len [NR];
    logic [PW-1:0] m_pl  [NR];
    logic [NR-1:0] pend, pend_c;
    logic          offer_c, offer_p, busy_c, busy_p, ordy_c, exp_grant, new_offer;
    logic [7:0]    h_cmd, h_len;
    logic [PW-1:0] h_pl;
    int            last_g, g, eg, grants;
    do_reset();
    pend = '0; offer_c = 1'b0; offer_p = 1'b0; busy_p = 1'b0;
    last_g = NR - 1; grants = 0;
    h_cmd = '0; h_len = '0; h_pl = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 700) begin
        for (int i = 0; i < NR; i++) begin
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            m_cmd[i] = 8'($urandom());
            m_len[i] = 8'($urandom_range(0, 20));
            m_pl[i]  = rand_pl();
            set_req(i, m_cmd[i], m_len[i], m_pl[i]);
            pend[i] = 1'b1;
          end
        end
      end
      bus.out_ready = (cyc >= 700) ? 1'b1 : ($urandom_range(0, 3) != 0);
      busy_len = $urandom_range(1, 5);
      pend_c = pend;
      ordy_c = bus.out_ready;
      busy_c = bus.tx_busy;
      tick();
      // A grant is due exactly when the arbiter was idle (no offer and
      // msp_tx free over the last two cycles) with something pending.
      exp_grant = !offer_c && !offer_p && !busy_c && !busy_p && (pend_c != '0);
      checks++;
      if ((bus.req_ready != '0) !== exp_grant) begin
        errors++; $display("FAIL rand_grant_timing cyc%0d: got ready=%b want grant=%b", cyc, bus.req_ready, exp_grant);
      end
      if (bus.req_ready != '0) begin
        g  = oh_idx(bus.req_ready);
        eg = rr_pick(pend_c, last_g);
        checks++;
        if (g != eg) begin
          errors++; $display("FAIL rand_grant_id cyc%0d: got %0d (ready=%b) want %0d", cyc, g, bus.req_ready, eg);
        end
        if (g >= 0) begin
          h_cmd = m_cmd[g];
          h_len = (m_len[g] > 8'(MP)) ? 8'(MP) : m_len[g];
          h_pl  = m_pl[g];
          checks++;
          if (bus.out_cmd !== h_cmd || bus.out_len !== h_len || bus.out_payload !== h_pl ||
              bus.len_err !== (m_len[g] > 8'(MP)) || bus.grant_id !== 3'(g)) begin
            errors++; $display("FAIL rand_data cyc%0d: got cmd=%h len=%0d err=%b id=%0d want cmd=%h len=%0d err=%b id=%0d", cyc, bus.out_cmd, bus.out_len, bus.len_err, bus.grant_id, h_cmd, h_len, m_len[g] > 8'(MP), g);
          end
          $display("random: cyc %0d grant %0d cmd=%h len=%0d", cyc, g, h_cmd, h_len);
          pend[g] = 1'b0;
          bus.req_valid[g] = 1'b0;
          last_g = g;
          grants++;
        end
      end else begin
        checks++;
        if (bus.len_err !== 1'b0) begin errors++; $display("FAIL rand_len_err cyc%0d: got 1 want 0", cyc); end
      end
      new_offer = (offer_c && !ordy_c) || (bus.req_ready != '0);
      checks++;
      if (bus.out_valid !== new_offer) begin
        errors++; $display("FAIL rand_out_valid cyc%0d: got %b want %b", cyc, bus.out_valid, new_offer);
      end
      if (new_offer && bus.req_ready == '0) begin
        checks++;
        if (bus.out_cmd !== h_cmd || bus.out_len !== h_len || bus.out_payload !== h_pl) begin
          errors++; $display("FAIL rand_hold cyc%0d: got cmd=%h len=%0d want cmd=%h len=%0d", cyc, bus.out_cmd, bus.out_len, h_cmd, h_len);
        end
      end
      offer_p = offer_c;
      offer_c = new_offer;
      busy_p  = busy_c;
    end
    checks++; if (pend != '0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain: got pend=%b valid=%b want 000/0", pend, bus.out_valid); end
    checks++; if (grants < 20) begin errors++; $display("FAIL rand_activity: got %0d grants want >=20", grants); end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_cmd     = '0;
    bus.req_len     = '0;
    bus.req_payload = '0;
    bus.req_valid   = '0;
    bus.out_ready   = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msp_tx_arbiter.md
Name: msp_tx_arbiter

Overview:
- Shares one msp_tx response transmitter between NUM_REQ response sources, e.g. the msp_responder and a periodic telemetry generator.
- Round-robin selects one pending response and latches its cmd, length and payload into a local buffer.
- Offers the buffered response to msp_tx over a valid/ready handshake.
- Holds off the next grant until msp_tx reports not busy, so only one MSP frame is in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- MAX_PAYLOAD, 16, payload bytes per response; must match the msp_tx instance.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_cmd  input  NUM_REQ*8  per-requester MSP command; requester i uses bits [i*8 +: 8].
- req_len  input  NUM_REQ*8  per-requester payload length, same packing as req_cmd.
- req_payload  input  NUM_REQ*MAX_PAYLOAD*8  per-requester payload; byte k of requester i is at [(i*MAX_PAYLOAD+k)*8 +: 8].
- req_valid  input  NUM_REQ  requester holds a response.
- req_ready  output  NUM_REQ  one-cycle accept pulse.
- out_cmd  output  8  to msp_tx resp_cmd.
- out_len  output  8  to msp_tx resp_len.
- out_payload  output  MAX_PAYLOAD*8  to msp_tx resp_payload.
- out_valid  output  1  to msp_tx resp_valid.
- out_ready  input  1  from msp_tx resp_ready.
- tx_busy  input  1  from msp_tx busy.
- grant_id  output  3  index of the last granted requester.
- len_err  output  1  one-cycle pulse when a length was clamped.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=S_IDLE, req_ready=0, out_valid=0, out_cmd=0, out_len=0, out_payload=0, len_err=0, grant_id=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins the first arbitration.
  - Reset asserted mid-operation aborts everything; any frame already inside msp_tx is not recalled.
- Requester rules:
  - req_valid stays high, with cmd/len/payload stable, until the cycle in which req_ready=1.
  - That cycle is consumption; req_valid may drop from the next cycle.
- S_IDLE:
  - If tx_busy=0 and any req_valid is set, pick the first set bit scanning from rr_ptr+1 upward modulo NUM_REQ. Call it g.
  - On that edge: latch req_cmd[g], req_len[g] and req_payload[g]; set req_ready[g]=1, out_valid=1, grant_id=g, rr_ptr=g; go to S_OFFER.
  - If tx_busy=1 or no request is pending, stay in S_IDLE with all outputs held.
- Length clamp: if req_len[g] > MAX_PAYLOAD, out_len=MAX_PAYLOAD and len_err pulses for the same cycle as req_ready. The payload is passed through unchanged.
- S_OFFER:
  - req_ready returns to 0 after one cycle.
  - When out_valid=1 and out_ready=1, clear out_valid on that edge and go to S_WAIT.
  - out_* are held stable while out_valid=1.
- S_WAIT:
  - Go to S_IDLE on the first cycle with tx_busy=0.
  - The cycle after the handshake always has tx_busy=1 (msp_tx asserts busy on the edge it latches), so at least one busy cycle is observed.
- Latency:
  - req_valid rise (arbiter idle, tx_busy=0) -> req_ready and out_valid high on the next cycle.
  - Handshake -> next grant no earlier than the first tx_busy=0 cycle + 1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 frames.
- Edge cases:
  - Requester re-asserting req_valid immediately after its own grant: it is placed last in the rotation.
  - NUM_REQ=1: always grants 0.
  - req_valid dropping illegally after it was sampled: the latched response is still sent.
  - req_len=0: forwarded unchanged.
- Index and pointer widths are 3 bits. rr_ptr+1 wraps to 0 at NUM_REQ.

Optional Feature:
- Macro MSP_TX_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16): per-requester grant counters, incremented on each req_ready pulse and saturating at 16'hFFFF.
  - Adds output len_err_cnt (8), saturating at 8'hFF.
  - Both counters clear on reset.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Single request:
  - Stimulus: requester 0 sends cmd=0x65, len=3, payload 01 02 03, out_ready=1, tx_busy=0.
  - Response: req_ready[0] high one cycle after req_valid; out_cmd=0x65, out_len=3; out_valid clears after one cycle; grant_id=0.
- Contention:
  - Stimulus: requesters 0 and 1 valid simultaneously, with a tx_busy model of 20 cycles per frame.
  - Response: grants in order 0, then 1. The second out_valid rises only after tx_busy falls.
- Round robin:
  - Stimulus: NUM_REQ=3, all requesters continuously valid for 6 frames.
  - Response: grant_id sequence 0,1,2,0,1,2.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles while out_valid=1.
  - Response: out_* stable, no new req_ready, and handshake on the first out_ready=1 cycle.
- Clamp:
  - Stimulus: req_len=20 with MAX_PAYLOAD=16.
  - Response: out_len=16 and len_err pulses once.
  - With MSP_TX_ARB_STATS_EN defined: len_err_cnt=1.
- Reset:
  - Stimulus: rst_n low while in S_OFFER.
  - Response: out_valid=0 and req_ready=0 immediately (asynchronously); after release, the next grant goes to requester 0.
